// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared types for the PCIe SS TX shims.
// Holds the scheduler FSM state encoding.
package ofs_fim_pcie_ss_shims_pkg;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_PKT  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/ofs_fim_pcie_ss_rr_pick.sv
// Round-robin first-valid search.
// Scans upward from ptr_i with wrap-around.
module ofs_fim_pcie_ss_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
        any_o = 1'b1;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/ofs_fim_pcie_ss_tx_sched.sv
// PCIe SS TX scheduler: weighted, packet-atomic round robin
// of NUM_CH AXI-S TLP sources into one registered stream.
module ofs_fim_pcie_ss_tx_sched
  import ofs_fim_pcie_ss_shims_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 512,
  parameter int USER_W         = 10,
  parameter int WEIGHT_W       = 4,
  parameter int DEFAULT_WEIGHT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          in_tvalid,
  output logic [NUM_CH-1:0]          in_tready,
  input  logic [NUM_CH*DATA_W-1:0]   in_tdata,
  input  logic [NUM_CH*DATA_W/8-1:0] in_tkeep,
  input  logic [NUM_CH-1:0]          in_tlast,
  input  logic [NUM_CH*USER_W-1:0]   in_tuser,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [DATA_W-1:0]          out_tdata,
  output logic [DATA_W/8-1:0]        out_tkeep,
  output logic                       out_tlast,
  output logic [USER_W-1:0]          out_tuser,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  input  logic [NUM_CH*WEIGHT_W-1:0] cfg_weight,
  input  logic                       cfg_load
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int KEEP_W = DATA_W / 8;

  typedef logic [WEIGHT_W-1:0] wt_t;

  sched_state_e      state_q;
  logic [CH_W-1:0]   cur_ch_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   rr_ptr_d;
  wt_t               credit_q [NUM_CH];
  wt_t               credit_d [NUM_CH];
  wt_t               weight_q [NUM_CH];
  wt_t               weight_d [NUM_CH];

  logic              vld_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;
  logic [KEEP_W-1:0] keep_q;
  logic [USER_W-1:0] user_q;
  logic [CH_W-1:0]   ch_q;

  logic [NUM_CH-1:0] pick_gnt;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic [CH_W-1:0]   sel;
  int unsigned       sel_n;
  logic              load;
  logic              accept;
  logic              sel_last;

  function automatic wt_t eff_w(wt_t w);
    return (w == '0) ? wt_t'(1) : w;
  endfunction

  ofs_fim_pcie_ss_rr_pick #(
    .N (NUM_CH)
  ) u_pick (
    .req_i (in_tvalid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel   = (state_q == SCHED_IDLE) ? pick_idx : cur_ch_q;
    sel_n = 32'(sel);
    load  = !vld_q || out_tready;
    in_tready = '0;
    if (!rst && load) begin
      if (state_q == SCHED_IDLE)
        in_tready = pick_any ? pick_gnt : '0;
      else
        in_tready[cur_ch_q] = 1'b1;
    end
    accept   = in_tvalid[sel] && in_tready[sel];
    sel_last = in_tlast[sel];
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      weight_d[c] = cfg_load ?
        cfg_weight[c*WEIGHT_W +: WEIGHT_W] : weight_q[c];
      credit_d[c] = credit_q[c];
    end
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      // Granting past rr_ptr forfeits the skipped channel's turn.
      if (state_q == SCHED_IDLE && sel != rr_ptr_q) begin
        credit_d[rr_ptr_q] = eff_w(weight_d[rr_ptr_q]);
        rr_ptr_d = sel;
      end
      if (sel_last) begin
        if (credit_q[sel] <= wt_t'(1)) begin
          credit_d[sel] = eff_w(weight_d[sel]);
          rr_ptr_d = (sel == CH_W'(NUM_CH - 1)) ?
            '0 : sel + 1'b1;
        end else begin
          credit_d[sel] = credit_q[sel] - 1'b1;
          rr_ptr_d = sel;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SCHED_IDLE;
      cur_ch_q <= '0;
      rr_ptr_q <= '0;
      vld_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        credit_q[c] <= eff_w(wt_t'(DEFAULT_WEIGHT));
        weight_q[c] <= wt_t'(DEFAULT_WEIGHT);
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int c = 0; c < NUM_CH; c++) begin
        credit_q[c] <= credit_d[c];
        weight_q[c] <= weight_d[c];
      end
      if (load)
        vld_q <= accept;
      if (accept) begin
        cur_ch_q <= sel;
        state_q  <= sel_last ? SCHED_IDLE : SCHED_PKT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= in_tdata[sel_n*DATA_W +: DATA_W];
      keep_q <= in_tkeep[sel_n*KEEP_W +: KEEP_W];
      user_q <= in_tuser[sel_n*USER_W +: USER_W];
      last_q <= sel_last;
      ch_q   <= sel;
    end
  end

  assign out_tvalid = vld_q;
  assign out_tdata  = data_q;
  assign out_tkeep  = keep_q;
  assign out_tuser  = user_q;
  assign out_tlast  = last_q;
  assign out_ch     = ch_q;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_sched.sv
// Bench for the TX scheduler: directed scenarios plus random
// traffic checked against a queue-based arbitration model.
module tb_ofs_fim_pcie_ss_tx_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int UW = 10;
  localparam int WW = 4;
  localparam int KW = DW / 8;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    int    ch;
    beat_t b;
  } ob_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    in_tvalid;
  logic [N-1:0]    in_tready;
  logic [N*DW-1:0] in_tdata;
  logic [N*KW-1:0] in_tkeep;
  logic [N-1:0]    in_tlast;
  logic [N*UW-1:0] in_tuser;
  logic            out_tvalid;
  logic            out_tready;
  logic [DW-1:0]   out_tdata;
  logic [KW-1:0]   out_tkeep;
  logic            out_tlast;
  logic [UW-1:0]   out_tuser;
  logic [CW-1:0]   out_ch;
  logic [N*WW-1:0] cfg_weight;
  logic            cfg_load;

  ofs_fim_pcie_ss_tx_sched #(
    .NUM_CH(N), .DATA_W(DW), .USER_W(UW),
    .WEIGHT_W(WW), .DEFAULT_WEIGHT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep),
    .in_tlast(in_tlast), .in_tuser(in_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep),
    .out_tlast(out_tlast), .out_tuser(out_tuser),
    .out_ch(out_ch),
    .cfg_weight(cfg_weight), .cfg_load(cfg_load)
  );

  always #5 clk = ~clk;

  beat_t src [N][$];
  bit    src_mid [N];
  ob_t   expq [$];
  int    out_log [$];
  int    out_cyc [$];
  int    m_rr, m_cur, m_cr [N], m_w [N];
  bit    m_busy;
  int    n_chk, n_fail, cyc;
  int    gap_pct, ready_pct, beats_in, beats_out;
  bit    stall, cfg_req;
  logic [N*WW-1:0] cfg_val;

  function automatic int eff(int w);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_reset();
    expq.delete();
    for (int c = 0; c < N; c++) begin
      src[c].delete();
      src_mid[c] = 1'b0;
      m_cr[c] = 1;
      m_w[c] = 1;
    end
    m_rr = 0;
    m_cur = 0;
    m_busy = 1'b0;
  endtask

  task automatic add_pkt(int c, int nb);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.d = $urandom;
      b.k = KW'($urandom);
      b.u = UW'($urandom);
      b.l = (i == nb - 1);
      src[c].push_back(b);
      beats_in++;
    end
  endtask

  task automatic drive();
    bit v;
    for (int c = 0; c < N; c++) begin
      v = src[c].size() > 0 &&
          (src_mid[c] || $urandom_range(99) >= gap_pct);
      in_tvalid[c] = v;
      in_tdata[c*DW +: DW] = '0;
      in_tkeep[c*KW +: KW] = '0;
      in_tuser[c*UW +: UW] = '0;
      in_tlast[c] = 1'b0;
      if (v) begin
        in_tdata[c*DW +: DW] = src[c][0].d;
        in_tkeep[c*KW +: KW] = src[c][0].k;
        in_tuser[c*UW +: UW] = src[c][0].u;
        in_tlast[c] = src[c][0].l;
      end
    end
    out_tready = !stall && ($urandom_range(99) < ready_pct);
    cfg_load = cfg_req;
    cfg_weight = cfg_val;
    cfg_req = 1'b0;
  endtask

  task automatic eval();
    int exp_ch, c;
    logic [N-1:0] efire, allowed, fire;
    bit mload;
    beat_t b;
    mload = (expq.size() == 0) || out_tready;
    n_chk++;
    if (out_tvalid) begin
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL out_spurious: out_tvalid=1 ch=%0d, required no beat",
                 out_ch);
      end else if (out_ch !== CW'(expq[0].ch) ||
                   out_tdata !== expq[0].b.d ||
                   out_tkeep !== expq[0].b.k ||
                   out_tuser !== expq[0].b.u ||
                   out_tlast !== expq[0].b.l) begin
        n_fail++;
        $display("FAIL out_beat: got ch=%0d d=%h k=%h u=%h l=%0b required ch=%0d d=%h k=%h u=%h l=%0b",
                 out_ch, out_tdata, out_tkeep, out_tuser, out_tlast,
                 expq[0].ch, expq[0].b.d, expq[0].b.k,
                 expq[0].b.u, expq[0].b.l);
      end
      if (out_tready) begin
        out_log.push_back(int'(out_ch));
        out_cyc.push_back(cyc);
        if (expq.size() > 0) begin
          expq.pop_front();
          beats_out++;
        end
      end
    end else if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL out_latency: out_tvalid=0, required 1 (%0d beats pending)",
               expq.size());
    end
    if (cfg_load)
      for (int i = 0; i < N; i++) m_w[i] = int'(cfg_weight[i*WW +: WW]);
    exp_ch = -1;
    if (mload) begin
      if (m_busy) begin
        if (in_tvalid[m_cur]) exp_ch = m_cur;
      end else begin
        for (int i = 0; i < N; i++)
          if (exp_ch < 0 && in_tvalid[(m_rr + i) % N])
            exp_ch = (m_rr + i) % N;
      end
    end
    efire = '0;
    if (exp_ch >= 0) efire[exp_ch] = 1'b1;
    allowed = !mload ? '0 : (m_busy ? (N'(1) << m_cur) : efire);
    fire = in_tvalid & in_tready;
    n_chk++;
    if (fire !== efire) begin
      n_fail++;
      $display("FAIL in_fire: got %b required %b (cyc %0d)",
               fire, efire, cyc);
    end
    n_chk++;
    if ((in_tready & ~allowed) !== '0) begin
      n_fail++;
      $display("FAIL in_ready: got %b allowed %b (cyc %0d)",
               in_tready, allowed, cyc);
    end
    if (exp_ch >= 0) begin
      c = exp_ch;
      b = src[c][0];
      expq.push_back('{ch: c, b: b});
      if (!m_busy && c != m_rr) begin
        m_cr[m_rr] = eff(m_w[m_rr]);
        m_rr = c;
      end
      if (b.l) begin
        m_busy = 1'b0;
        if (m_cr[c] <= 1) begin
          m_cr[c] = eff(m_w[c]);
          m_rr = (c + 1) % N;
        end else begin
          m_cr[c]--;
          m_rr = c;
        end
      end else begin
        m_busy = 1'b1;
        m_cur = c;
      end
    end
    for (int i = 0; i < N; i++)
      if (fire[i] === 1'b1 && src[i].size() > 0) begin
        src_mid[i] = !src[i][0].l;
        src[i].pop_front();
      end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    if (!rst) eval();
    cyc++;
  endtask

  task automatic run_outs(int n, int budget, string name);
    int target;
    target = out_log.size() + n;
    for (int k = 0; k < budget && out_log.size() < target; k++)
      cycle();
    n_chk++;
    if (out_log.size() < target) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats, required %0d",
               name, out_log.size() - target + n, n);
    end
  endtask

  task automatic check_seq(int s, int exp_s[$], string name);
    for (int i = 0; i < exp_s.size(); i++) begin
      n_chk++;
      if (out_log.size() <= s + i || out_log[s+i] != exp_s[i]) begin
        n_fail++;
        $display("FAIL %s_seq[%0d]: got %0d required %0d", name, i,
                 (out_log.size() > s + i) ? out_log[s+i] : -1, exp_s[i]);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    in_tvalid = '1;
    out_tready = 1'b1;
    #2;
    n_chk++;
    if (out_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_tvalid: got %b required 0", out_tvalid);
    end
    n_chk++;
    if (in_tready !== '0) begin
      n_fail++;
      $display("FAIL reset_in_tready: got %b required 0000", in_tready);
    end
    in_tvalid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rr_equal();
    int s;
    int e[$] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 3; k++) add_pkt(c, 1);
    s = out_log.size();
    run_outs(12, 60, "rr_equal");
    check_seq(s, e, "rr_equal");
    n_chk++;
    if (out_log.size() < s + 12 || out_cyc[s+11] - out_cyc[s] != 11) begin
      n_fail++;
      $display("FAIL rr_equal_gap: got span %0d required 11",
               (out_log.size() >= s + 12) ? out_cyc[s+11] - out_cyc[s] : -1);
    end
  endtask

  task automatic test_weighted();
    int s;
    int e[$] = '{0, 1, 2, 3, 0, 0, 0, 1, 2, 3, 0, 0, 0};
    cfg_val = {4'd1, 4'd1, 4'd1, 4'd3};
    cfg_req = 1'b1;
    cycle();
    for (int k = 0; k < 7; k++) add_pkt(0, 1);
    for (int c = 1; c < N; c++) begin
      add_pkt(c, 1);
      add_pkt(c, 1);
    end
    s = out_log.size();
    run_outs(13, 80, "weighted");
    check_seq(s, e, "weighted");
  endtask

  task automatic test_lock();
    int s;
    int e[$] = '{1, 1, 1, 1, 2, 2, 2, 2};
    cfg_val = {4'd1, 4'd1, 4'd1, 4'd1};
    cfg_req = 1'b1;
    cycle();
    add_pkt(1, 4);
    add_pkt(2, 2);
    add_pkt(2, 2);
    s = out_log.size();
    run_outs(8, 60, "lock");
    check_seq(s, e, "lock");
    n_chk++;
    if (out_log.size() < s + 4 || out_cyc[s+3] - out_cyc[s] != 3) begin
      n_fail++;
      $display("FAIL lock_contig: ch1 beats not contiguous");
    end
  endtask

  task automatic test_backpressure();
    int s;
    int e[$] = '{3, 3, 3, 0, 0, 0};
    add_pkt(3, 3);
    add_pkt(0, 3);
    s = out_log.size();
    run_outs(1, 20, "bp_first");
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_chk++;
      if (in_tready !== '0 || out_tvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall: in_tready=%b out_tvalid=%b required 0000/1",
                 in_tready, out_tvalid);
      end
    end
    stall = 1'b0;
    run_outs(5, 40, "bp_rest");
    check_seq(s, e, "bp");
  endtask

  task automatic test_reset_midpkt();
    int s;
    int e[$] = '{0, 0, 2};
    add_pkt(1, 3);
    for (int k = 0; k < 20 && src[1].size() != 2; k++) cycle();
    n_chk++;
    if (src[1].size() != 2) begin
      n_fail++;
      $display("FAIL rstpkt_timeout: %0d beats left, required 2",
               src[1].size());
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (out_tvalid !== 1'b0 || in_tready !== '0) begin
      n_fail++;
      $display("FAIL rstpkt_outputs: out_tvalid=%b in_tready=%b required 0/0000",
               out_tvalid, in_tready);
    end
    in_tvalid = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    add_pkt(2, 1);
    add_pkt(0, 2);
    s = out_log.size();
    run_outs(3, 30, "rstpkt");
    check_seq(s, e, "rstpkt");
  endtask

  task automatic test_cfg_midturn();
    int s;
    int e0[$] = '{0, 1};
    int e[$] = '{0, 0, 0, 1, 0, 0, 1, 0};
    cfg_val = {4'd1, 4'd1, 4'd1, 4'd3};
    cfg_req = 1'b1;
    cycle();
    add_pkt(0, 1);
    add_pkt(1, 1);
    s = out_log.size();
    run_outs(2, 20, "cfg_pre");
    check_seq(s, e0, "cfg_pre");
    for (int k = 0; k < 6; k++) add_pkt(0, 1);
    add_pkt(1, 1);
    add_pkt(1, 1);
    s = out_log.size();
    run_outs(1, 20, "cfg_first");
    cfg_val = {4'd1, 4'd1, 4'd1, 4'd2};
    cfg_req = 1'b1;
    run_outs(7, 40, "cfg_rest");
    check_seq(s, e, "cfg");
  endtask

  task automatic test_random();
    int k;
    beats_in = 0;
    beats_out = 0;
    ready_pct = 70;
    gap_pct = 25;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 35) begin
        k = $urandom_range(N - 1);
        if (src[k].size() < 8) add_pkt(k, $urandom_range(1, 4));
      end
      if ($urandom_range(99) < 3) begin
        for (int c = 0; c < N; c++)
          cfg_val[c*WW +: WW] = WW'($urandom_range(15));
        cfg_req = 1'b1;
      end
      cycle();
    end
    ready_pct = 100;
    gap_pct = 0;
    k = 0;
    while (k < 500 && (expq.size() != 0 || src[0].size() != 0 ||
           src[1].size() != 0 || src[2].size() != 0 ||
           src[3].size() != 0)) begin
      cycle();
      k++;
    end
    n_chk++;
    if (beats_out != beats_in) begin
      n_fail++;
      $display("FAIL random_count: got %0d beats out, required %0d",
               beats_out, beats_in);
    end
  endtask

  initial begin
    in_tvalid = '0;
    in_tdata = '0;
    in_tkeep = '0;
    in_tlast = '0;
    in_tuser = '0;
    out_tready = 1'b0;
    cfg_weight = '0;
    cfg_load = 1'b0;
    cfg_val = '0;
    cfg_req = 1'b0;
    stall = 1'b0;
    gap_pct = 0;
    ready_pct = 100;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    beats_in = 0;
    beats_out = 0;
    model_reset();
    test_reset();
    test_rr_equal();
    test_weighted();
    test_lock();
    test_backpressure();
    test_reset_midpkt();
    test_cfg_midturn();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ofs_fim_pcie_ss_tx_sched.md
OFS_FIM_PCIE_SS_TX_SCHED -- requirements
Module: ofs_fim_pcie_ss_tx_sched

Interface
REQ-001 The block SHALL have these parameters:
- NUM_CH, 4, number of TLP source channels (2..8).
- DATA_W, 512, tdata width per channel.
- USER_W, 10, tuser_vendor width per channel.
- WEIGHT_W, 4, per-channel weight width.
- DEFAULT_WEIGHT, 1, weight used after reset.

REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_tvalid  in  NUM_CH  per-channel valid.
- in_tready  out  NUM_CH  per-channel ready.
- in_tdata  in  NUM_CH*DATA_W  per-channel data.
- in_tkeep  in  NUM_CH*DATA_W/8  per-channel byte enables.
- in_tlast  in  NUM_CH  per-channel end of packet.
- in_tuser  in  NUM_CH*USER_W  per-channel tuser_vendor.
- out_tvalid  out  1  merged valid.
- out_tready  in  1  downstream ready.
- out_tdata  out  DATA_W  merged data.
- out_tkeep  out  DATA_W/8  merged byte enables.
- out_tlast  out  1  merged end of packet.
- out_tuser  out  USER_W  merged tuser_vendor.
- out_ch  out  $clog2(NUM_CH)  source channel of the current output beat.
- cfg_weight  in  NUM_CH*WEIGHT_W  packets per turn, per channel.
- cfg_load  in  1  one-cycle pulse that captures cfg_weight.

Function
REQ-003 The block SHALL be packet-atomic: once a channel's first beat is accepted, no other channel is granted until that channel's tlast beat is accepted.
REQ-004 The FSM SHALL have two states. IDLE: no packet open. PKT: locked to cur_ch.
REQ-005 In IDLE, the block SHALL grant the first valid channel searching upward from rr_ptr with wrap-around. It SHALL accept that channel's first beat in the same cycle (no bubble).
REQ-006 Transitions:
- IDLE -> PKT on an accepted beat with tlast=0.
- A single-beat packet leaves the FSM in IDLE.
- PKT -> IDLE on an accepted beat with tlast=1.
REQ-007 in_tready[c] SHALL be 1 only for the granted channel, and only when the output stage can load (!out_tvalid || out_tready).
REQ-008 Output timing:
- The output stage SHALL be a single registered stage with 1-cycle latency.
- It SHALL hold all out_* signals stable while out_tvalid && !out_tready.
- It SHALL sustain one beat per cycle under continuous ready.
REQ-009 Each channel SHALL have a credit counter, decremented by 1 when that channel's tlast beat is accepted.
REQ-010 If the decrement reaches 0, the block SHALL reload the counter from the weight register and set rr_ptr to cur_ch+1 modulo NUM_CH. Otherwise rr_ptr SHALL stay at cur_ch.
REQ-011 If a grant goes to a channel other than rr_ptr, the block SHALL reload the skipped rr_ptr channel's credit and set rr_ptr to the granted channel.
REQ-012 Weight value 0 SHALL be treated as 1.
REQ-013 cfg_load SHALL update the weight registers only. It SHALL take effect at each channel's next reload and SHALL NOT change credits mid-turn.
REQ-014 A channel dropping tvalid while in PKT SHALL stall the output (no grant change). This is legal but not expected.
REQ-015 If cfg_load and a reload happen in the same cycle, the reload SHALL use the new weight.

Reset
REQ-016 On rst, asynchronously, the block SHALL set:
- FSM to IDLE, rr_ptr to 0, cur_ch to 0;
- all credits and weights to DEFAULT_WEIGHT;
- out_tvalid to 0 and in_tready to all 0.
Output data registers need no reset.
REQ-017 Reset asserted mid-packet SHALL discard the partial packet. The first beat after reset release SHALL be treated as a new packet.

Structure
REQ-018 The FSM state enum (SCHED_IDLE, SCHED_PKT) SHALL be defined in ofs_fim_pcie_ss_shims_pkg.
REQ-019 The round-robin first-valid search SHALL be one combinational sub-module, ofs_fim_pcie_ss_rr_pick (inputs: request vector, start pointer; outputs: one-hot grant, index, any).

Verification
REQ-020 The bench SHALL cover these scenarios:
- NUM_CH=4, weights all 1, every channel streaming single-beat packets, out_tready=1 -> out_ch sequence 0,1,2,3,0,... with no idle cycles.
- Weights {3,1,1,1}, all channels streaming 1-beat packets -> out_ch sequence 0,0,0,1,2,3,0,0,0.
- Ch1 sends a 4-beat packet while ch2 is valid -> all 4 beats carry out_ch=1 contiguously, then ch2 is granted.
- out_tready held low for 5 cycles mid-packet -> out_* is stable, in_tready is all 0, and no beat is lost or duplicated.
- cfg_load with weight 2 for ch0 during ch0's turn at weight 3 -> the current turn completes 3 packets and the next turn uses 2.
- rst asserted during beat 2 of a 3-beat packet -> out_tvalid=0 and rr_ptr=0 after reset; the next grant starts a fresh packet.
